// File: rtl/msgpass_pagealign_pipe.sv
// Pipelined permutation and page-alignment stage. A packed layer of extrinsic
// messages is rotated by a per-beat shift factor. Each stride is then aligned:
// taken from the current beat, from a short history of earlier beats, or from
// the memory source. The aligned strides are merged into a held output bus
// under per-stride load enables. Flow control uses a valid/ready handshake.
module msgpass_pagealign_pipe #(
  parameter  int SHIFT_LENGTH = 17,
  parameter  int QUAN_SIZE    = 4,
  parameter  int PIPE_STAGES  = 2,
  parameter  int DELAY_DEPTH  = 2,
  localparam int SEL_W        = $clog2(DELAY_DEPTH + 2),
  localparam int SF_W         = $clog2(SHIFT_LENGTH)
) (
  input  logic                            sys_clk,
  input  logic                            rstn,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [SHIFT_LENGTH*QUAN_SIZE-1:0] msg_in_i,
  input  logic [SF_W-1:0]                 shift_factor_i,
  input  logic [SHIFT_LENGTH*SEL_W-1:0]   pa_sel_i,
  input  logic [SHIFT_LENGTH*QUAN_SIZE-1:0] mem_in_i,
  input  logic [SHIFT_LENGTH-1:0]         combine_en_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [SHIFT_LENGTH*QUAN_SIZE-1:0] msg_out_o,
  output logic                            err_o
);

  localparam int W = SHIFT_LENGTH * QUAN_SIZE;

  // One beat as it travels down the pipe. The rotation is already applied.
  typedef struct packed {
    logic                          valid;
    logic                          err;
    logic [W-1:0]                  shifted;
    logic [SHIFT_LENGTH*SEL_W-1:0] sel;
    logic [W-1:0]                  mem;
    logic [SHIFT_LENGTH-1:0]       en;
  } beat_t;

  logic         adv;
  beat_t        in_beat;
  beat_t        fin;
  logic [W-1:0] aligned;
  logic         sel_bad;
  logic [W-1:0] dly [DELAY_DEPTH];   // dly[0] holds the previous valid beat

  // Every stage moves together whenever the output slot is free or being drained.
  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;

  // Capture the input controls and rotate the strides toward higher indices.
  // An out-of-range shift factor falls back to pass-through and marks the beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_beat       = '0;
    in_beat.valid = in_valid_i;
    in_beat.err   = int'(shift_factor_i) >= SHIFT_LENGTH;
    in_beat.sel   = pa_sel_i;
    in_beat.mem   = mem_in_i;
    in_beat.en    = combine_en_i;
    for (int k = 0; k < SHIFT_LENGTH; k++) begin : g_rot
      int sh;
      int src;
      sh  = in_beat.err ? 0 : int'(shift_factor_i);
      src = k - sh;
      if (src < 0) src = src + SHIFT_LENGTH;
      in_beat.shifted[k*QUAN_SIZE +: QUAN_SIZE] = msg_in_i[src*QUAN_SIZE +: QUAN_SIZE];
    end
  end

  if (PIPE_STAGES == 1) begin : g_direct
    assign fin = in_beat;
  end else begin : g_pipe
    beat_t stg [PIPE_STAGES-1];

    // Intermediate stage registers. Only the valid bits need a reset.
    always_ff @(posedge sys_clk) begin
      // NOTE: payload fields are not reset; a beat's data is ignored while its valid bit is low.
      if (!rstn) begin
        for (int i = 0; i < PIPE_STAGES - 1; i++) stg[i].valid <= 1'b0;
      end else if (adv) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        stg[0] <= in_beat;
        for (int i = 1; i < PIPE_STAGES - 1; i++) stg[i] <= stg[i-1];
      end
    end

    assign fin = stg[PIPE_STAGES-2];
  end

  // Per-stride page alignment of the beat in the final stage.
  always_comb begin
    aligned = '0;
    sel_bad = 1'b0;
    for (int k = 0; k < SHIFT_LENGTH; k++) begin : g_align
      int v;
      v = int'(fin.sel[k*SEL_W +: SEL_W]);
      if (v == 0)
        aligned[k*QUAN_SIZE +: QUAN_SIZE] = fin.shifted[k*QUAN_SIZE +: QUAN_SIZE];
      else if (v <= DELAY_DEPTH)
        aligned[k*QUAN_SIZE +: QUAN_SIZE] = dly[v-1][k*QUAN_SIZE +: QUAN_SIZE];
      else if (v == DELAY_DEPTH + 1)
        aligned[k*QUAN_SIZE +: QUAN_SIZE] = fin.mem[k*QUAN_SIZE +: QUAN_SIZE];
      else
        sel_bad = 1'b1;
    end
  end

  // History of rotated beats. It ages only when a valid beat leaves the pipe.
  always_ff @(posedge sys_clk) begin
    // NOTE: the delay line is reset because the first beats after reset read it through delayed selects.
    if (!rstn) begin
      for (int d = 0; d < DELAY_DEPTH; d++) dly[d] <= '0;
    end else if (adv && fin.valid) begin
      dly[0] <= fin.shifted;
      for (int d = 1; d < DELAY_DEPTH; d++) dly[d] <= dly[d-1];
    end
  end

  // Output bus merge under the per-stride enables, output valid, sticky error.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      out_valid_o <= 1'b0;
      msg_out_o   <= '0;
      err_o       <= 1'b0;
    end else if (adv) begin
      out_valid_o <= fin.valid;
      if (fin.valid) begin
        for (int k = 0; k < SHIFT_LENGTH; k++)
          if (fin.en[k]) msg_out_o[k*QUAN_SIZE +: QUAN_SIZE] <= aligned[k*QUAN_SIZE +: QUAN_SIZE];
        if (fin.err || sel_bad) err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msgpass_pagealign_pipe.sv
// Scoreboard bench for msgpass_pagealign_pipe. A reference model predicts the
// output bus and error flag for each accepted beat. Predictions are queued and
// compared as the DUT hands beats downstream. A second instance with a deeper
// delay line exercises the illegal alignment select.
module tb_msgpass_pagealign_pipe;

  localparam int SL    = 17;
  localparam int Q     = 4;
  localparam int DD    = 2;
  localparam int SEL_W = 2;
  localparam int SF_W  = 5;
  localparam int W     = SL * Q;

  logic              sys_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      msg_in = '0;
  logic [SF_W-1:0]   shift_factor = '0;
  logic [SL*SEL_W-1:0] pa_sel = '0;
  logic [SL*3-1:0]   pa_sel3 = '0;
  logic [W-1:0]      mem_in = '0;
  logic [SL-1:0]     combine_en = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [W-1:0]      msg_out;
  logic              err;
  logic              in_ready3, out_valid3, err3;
  logic [W-1:0]      msg_out3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] msg;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [Q-1:0] m_dly [DD][SL];
  logic [W-1:0] m_out;
  logic         m_err;

  always #5 sys_clk = ~sys_clk;

  msgpass_pagealign_pipe u_dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .msg_in_i(msg_in), .shift_factor_i(shift_factor), .pa_sel_i(pa_sel),
    .mem_in_i(mem_in), .combine_en_i(combine_en),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .msg_out_o(msg_out), .err_o(err)
  );

  msgpass_pagealign_pipe #(.DELAY_DEPTH(3)) u_dut3 (
    .sys_clk(sys_clk), .rstn(rstn),
    .in_valid_i(in_valid), .in_ready_o(in_ready3),
    .msg_in_i(msg_in), .shift_factor_i(shift_factor), .pa_sel_i(pa_sel3),
    .mem_in_i(mem_in), .combine_en_i(combine_en),
    .out_valid_o(out_valid3), .out_ready_i(out_ready),
    .msg_out_o(msg_out3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fill_msg(input logic [Q-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < SL; k++) r[k*Q +: Q] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp_msg();
    logic [W-1:0] r;
    for (int k = 0; k < SL; k++) r[k*Q +: Q] = Q'(k);
    return r;
  endfunction

  function automatic logic [SL*SEL_W-1:0] fill_sel(input int v);
    logic [SL*SEL_W-1:0] r;
    for (int k = 0; k < SL; k++) r[k*SEL_W +: SEL_W] = SEL_W'(v);
    return r;
  endfunction

  // Reference model: rotate, align, merge, age the history, queue the prediction.
  task automatic model_accept(input logic [W-1:0] msg, input logic [SF_W-1:0] s,
                              input logic [SL*SEL_W-1:0] sel, input logic [W-1:0] mem,
                              input logic [SL-1:0] en);
    logic [Q-1:0] sh [SL];
    logic [Q-1:0] a;
    int ss;
    int v;
    exp_t e;
    ss = int'(s);
    if (ss >= SL) begin
      ss = 0;
      m_err = 1'b1;
    end
    for (int k = 0; k < SL; k++) sh[k] = msg[((k - ss + SL) % SL)*Q +: Q];
    for (int k = 0; k < SL; k++) begin
      v = int'(sel[k*SEL_W +: SEL_W]);
      if (v == 0)            a = sh[k];
      else if (v <= DD)      a = m_dly[v-1][k];
      else if (v == DD + 1)  a = mem[k*Q +: Q];
      else begin
        a = '0;
        m_err = 1'b1;
      end
      if (en[k]) m_out[k*Q +: Q] = a;
    end
    for (int d = DD - 1; d > 0; d--) m_dly[d] = m_dly[d-1];
    m_dly[0] = sh;
    e.msg = m_out;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_out = '0;
    m_err = 1'b0;
    for (int d = 0; d < DD; d++)
      for (int k = 0; k < SL; k++) m_dly[d][k] = '0;
  endtask

  // Offer one beat until it is accepted; the model sees it on acceptance.
  task automatic send(input logic [W-1:0] msg, input logic [SF_W-1:0] s,
                      input logic [SL*SEL_W-1:0] sel, input logic [W-1:0] mem,
                      input logic [SL-1:0] en);
    int  tries = 0;
    bit  done  = 0;
    while (!done) begin
      @(negedge sys_clk);
      msg_in = msg; shift_factor = s; pa_sel = sel; mem_in = mem; combine_en = en;
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        model_accept(msg, s, sel, mem, en);
        done = 1;
      end
      @(posedge sys_clk);
      #1 in_valid = 1'b0;
      tries++;
      if (!done && tries > 50) begin
        check("send_timeout", 1, 0);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge sys_clk);
      #3;
      if (exp_q.size() == 0) ok = 1;
    end
    check("drain", W'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rstn = 1'b0;
    in_valid = 1'b0;
    model_clear();
    @(negedge sys_clk);
    rstn = 1'b1;
    #1;
  endtask

  // Monitor: compare each beat as it is consumed downstream.
  always @(negedge sys_clk) begin
    #1;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_msg", msg_out, e.msg);
        check("out_err", W'(err), W'(e.err));
      end
    end
  end

  initial begin
    logic [W-1:0] ref_out;
    logic [W-1:0] exp_v;
    bit           have_ref;
    bit           saw_low;
    int           cyc;

    model_clear();
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    #1;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_msg_out", msg_out, '0);
    check("rst_err", W'(err), 0);
    check("rst_in_ready", W'(in_ready), 1);

    // Rotation by 3 and the two-cycle latency.
    send(ramp_msg(), 5'd3, fill_sel(0), '0, '1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      #2;
      cyc++;
      if (out_valid) break;
    end
    check("latency", W'(cyc), 2);
    wait_drain();
    check("rot3_stride0", W'(msg_out[0 +: Q]), 14);
    check("rot3_stride3", W'(msg_out[3*Q +: Q]), 0);
    check("rot3_err", W'(err), 0);

    // One-beat delayed select.
    send(fill_msg(4'h5), '0, fill_sel(0), '0, '1);
    send(fill_msg(4'h9), '0, fill_sel(1), '0, '1);
    wait_drain();
    check("sel1_prev_beat", msg_out, fill_msg(4'h5));

    // Two-beat delayed select with a bubble in between.
    send(fill_msg(4'h5), '0, fill_sel(0), '0, '1);
    idle(2);
    send(fill_msg(4'h9), '0, fill_sel(0), '0, '1);
    send(fill_msg(4'hC), '0, fill_sel(2), '0, '1);
    wait_drain();
    check("sel2_bubble", msg_out, fill_msg(4'h5));

    // Memory source, then a single-stride merge.
    send(fill_msg(4'h1), '0, fill_sel(3), fill_msg(4'hA), '1);
    wait_drain();
    check("sel_mem", msg_out, fill_msg(4'hA));
    send(fill_msg(4'h2), '0, fill_sel(0), '0, 17'h00001);
    wait_drain();
    exp_v = fill_msg(4'hA);
    exp_v[0 +: Q] = 4'h2;
    check("combine_en_one", msg_out, exp_v);

    // Backpressure: five stalled cycles while three beats are offered.
    have_ref = 0;
    saw_low  = 0;
    fork
      begin
        send(fill_msg(4'h1), 5'd1, fill_sel(0), '0, '1);
        send(fill_msg(4'h2), 5'd2, fill_sel(1), '0, '1);
        send(fill_msg(4'h3), 5'd4, fill_sel(2), '0, '1);
      end
      begin
        @(negedge sys_clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge sys_clk);
          #2;
          if (!in_ready) saw_low = 1;
          if (out_valid) begin
            if (have_ref) check("stall_stable", msg_out, ref_out);
            ref_out  = msg_out;
            have_ref = 1;
          end
        end
        @(negedge sys_clk);
        out_ready = 1'b1;
      end
    join
    check("stall_in_ready_low", W'(saw_low), 1);
    wait_drain();

    // Illegal alignment select on the deeper instance.
    pa_sel3 = '0;
    pa_sel3[2*3 +: 3] = 3'd7;
    send(fill_msg(4'h6), '0, fill_sel(0), '0, '1);
    wait_drain();
    pa_sel3 = '0;
    check("badsel_stride2", W'(msg_out3[2*Q +: Q]), 0);
    check("badsel_stride0", W'(msg_out3[0 +: Q]), 6);
    check("badsel_err", W'(err3), 1);
    check("badsel_main_err", W'(err), 0);

    // Out-of-range shift factor: unshifted output, sticky error.
    send(ramp_msg(), 5'd17, fill_sel(0), '0, '1);
    wait_drain();
    check("s17_unshifted", msg_out, ramp_msg());
    check("s17_err", W'(err), 1);
    send(fill_msg(4'h4), 5'd5, fill_sel(0), '0, '1);
    wait_drain();
    check("err_sticky", W'(err), 1);

    // Full-rate burst with mixed controls.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0]        rm, rmem;
      logic [SL*SEL_W-1:0] rs;
      for (int k = 0; k < SL; k++) begin
        rm[k*Q +: Q]     = Q'($urandom);
        rmem[k*Q +: Q]   = Q'($urandom);
        rs[k*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 3));
      end
      send(rm, SF_W'($urandom_range(0, SL - 1)), rs, rmem, SL'($urandom));
    end
    wait_drain();

    // Reset with two beats in flight.
    send(fill_msg(4'h7), 5'd1, fill_sel(0), '0, '1);
    send(fill_msg(4'h8), 5'd2, fill_sel(0), '0, '1);
    do_reset();
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_msg_out", msg_out, '0);
    check("midrst_err", W'(err), 0);
    send(fill_msg(4'h7), '0, fill_sel(1), '0, '1);
    wait_drain();
    check("post_rst_sel1", msg_out, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msgpass_pagealign_pipe.md
Name: msgpass_pagealign_pipe

Overview:
Parametrised, pipelined successor to the level-2 permutation / page-alignment interface. It takes one packed layer of SHIFT_LENGTH extrinsic messages, circularly shifts them by a per-beat factor, applies per-stride page alignment (direct, delayed by 1..DELAY_DEPTH beats, or memory bypass), and merges the result into a held output bus through per-stride load enables. It sits between the level-1 message-passing network and the extrinsic message RAM. A valid/ready handshake provides backpressure.

Parameters:
SHIFT_LENGTH, 17, number of strides (circulant size); legal range 2..64
QUAN_SIZE, 4, message bit width; legal range 2..8
PIPE_STAGES, 2, accept-to-output latency in cycles; legal range 1..3
DELAY_DEPTH, 2, maximum per-stride alignment delay in beats; legal range 1..4
SEL_W (local), clog2(DELAY_DEPTH+2), width of one per-stride select field
SF_W (local), clog2(SHIFT_LENGTH), width of the shift factor

Ports:
sys_clk  in  1  clock
rstn  in  1  reset: synchronous, active-low; clock sys_clk
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i and in_ready_o are both high
msg_in_i  in  SHIFT_LENGTH*QUAN_SIZE  stride k occupies bits [k*QUAN_SIZE +: QUAN_SIZE]
shift_factor_i  in  SF_W  circular shift amount s
pa_sel_i  in  SHIFT_LENGTH*SEL_W  per-stride alignment select
mem_in_i  in  SHIFT_LENGTH*QUAN_SIZE  per-stride memory-source messages
combine_en_i  in  SHIFT_LENGTH  per-stride load enable for the output bus
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream ready
msg_out_o  out  SHIFT_LENGTH*QUAN_SIZE  combined, aligned messages
err_o  out  1  sticky illegal-control flag

Behaviour:
- Reset: msg_out_o=0, out_valid_o=0, err_o=0, every stage valid bit=0, every delay-line entry=0. in_ready_o=1 in the cycle after reset deasserts.
- Advance enable adv = out_ready_i | ~out_valid_o. All pipeline stages move together on adv. in_ready_o=adv, combinational, with no dependency on in_valid_i.
- On accept, msg_in_i, shift_factor_i, pa_sel_i, mem_in_i and combine_en_i are captured together and travel as one beat.
- A beat accepted in cycle t sets out_valid_o in cycle t+PIPE_STAGES, provided no stall occurs. A stall holds every stage and out_valid_o/msg_out_o stay stable. Bubbles propagate with their valid bit low.
- Shift: shifted stride k = input stride (k - s) mod SHIFT_LENGTH, i.e. rotate toward higher indices. s=0 is pass-through.
- s >= SHIFT_LENGTH is illegal: the beat is shifted by 0 and err_o is set.
- Alignment is applied in the final stage, per stride k, with select v:
  - v=0: shifted[k] of the current beat.
  - v=d, 1<=d<=DELAY_DEPTH: shifted[k] of the valid beat d beats earlier.
  - v=DELAY_DEPTH+1: mem_in[k] of the current beat.
  - Any other v: the aligned value is 0 and err_o is set.
- Delay line: per-stride shift register of depth DELAY_DEPTH. It shifts in shifted[k] only when a valid beat leaves the final stage, so bubbles and stalls do not age it.
- Combiner: when a valid beat leaves the final stage, msg_out_o[k] loads the aligned value if combine_en[k]=1 and holds its previous value otherwise. out_valid_o goes high for that beat even if every combine_en bit is 0.
- err_o stays high until reset. The datapath continues operating after an error.
- Reset mid-operation discards all in-flight beats and clears the delay lines. The first beat after reset sees zeros at any delayed select.
- Simultaneous accept, output consume and delay-line update in one cycle is normal operation. Throughput is one beat per cycle when out_ready_i is held high.

Test Plan:
- Defaults, 4-bit, msg_in stride k=k, s=3, all sel=0, all combine_en=1, out_ready_i=1 -> 2 cycles later msg_out stride k=(k-3) mod 17 (stride0=14, stride3=0); err_o=0.
- Beats A (all strides 5) then B (all strides 9), s=0, B sent with all sel=1 -> B output is all 5. Repeat with sel=2 and a third beat C -> C output is all 5; a bubble inserted between beats does not change these results.
- s=0, sel=3 (mem), mem_in all 0xA, msg_in all 0x1 -> output all 0xA. Then combine_en=0x00001 with msg_in all 0x2, sel=0 -> stride0=0x2, strides1..16 stay 0xA.
- out_ready_i=0 for 5 cycles while 3 beats are offered -> in_ready_o drops once the output holds a valid beat; msg_out_o is stable throughout; after release the beats emerge in order with none lost or duplicated.
- s=17 -> unshifted output and err_o=1. Also sel=7 on stride 2 -> stride 2 output=0 and err_o=1. err_o stays high until a rstn pulse.
- Reset asserted with 2 beats in flight -> out_valid_o=0 and msg_out_o=0 next cycle; first post-reset beat with sel=1 outputs 0.
